mem_load_reg: RTL and testbench
===============================

# mem_load_reg

Parametrised memory data register for the multi-cycle MIPS datapath with load-type handling. It replaces the plain always-loading data register between data memory and the register-file write-back mux. It accepts a load request, waits a variable number of cycles for memory, then captures the word. It extracts and sign- or zero-extends the addressed byte, halfword or word, and holds the result with a valid flag until consumed, with timeout and fault reporting.

## Interface
Parameters:
- WAIT_MAX, 15: maximum cycles spent in WAIT before Timeout; range 1..255.
- CNT_W, $clog2(WAIT_MAX+1): wait-counter width (derived, not overridden).

Ports:
- CLK  in  1  clock, all state on rising edge.
- Reset  in  1  reset Reset, synchronous, active-high; clock CLK.
- Load_Req  in  1  start a load (single-cycle strobe).
- Load_Type  in  3  opcode[2:0]: 000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU; others illegal.
- Addr_Lsb  in  2  byte address bits [1:0] of the load.
- Flush  in  1  abort any load in progress.
- Consume  in  1  write-back has taken Data_Out.
- Mem_Ready  in  1  memory read data valid this cycle.
- Mem_Data  in  32  raw memory word.
- Data_Out  out  32  extended load result.
- Data_Valid  out  1  Data_Out holds an unconsumed result.
- Busy  out  1  high in WAIT.
- Fault  out  1  one-cycle pulse: illegal type or misaligned request.
- Timeout  out  1  one-cycle pulse: WAIT_MAX exceeded.

## Operation
- States: IDLE, WAIT, HOLD.
- Load_Req is accepted in IDLE, or in HOLD when Consume is high in the same cycle; ignored otherwise (WAIT, or HOLD without Consume).
- On acceptance, Load_Type and Addr_Lsb are latched.
  - Legal and aligned: go to WAIT and clear the counter.
  - Illegal type, LH/LHU with Addr_Lsb[0]=1, or LW with Addr_Lsb!=00: Fault pulses next cycle; go to IDLE; Data_Out unchanged.
- Byte lanes are little-endian: byte k = Mem_Data[8k+7:8k]; halfword at Addr_Lsb[1] = Mem_Data[16h+15:16h].
- Extension:
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- WAIT with Mem_Ready: the extracted value is registered into Data_Out; go to HOLD.
- WAIT without Mem_Ready: counter increments. At counter == WAIT_MAX-1 with no Mem_Ready, Timeout pulses next cycle; go to IDLE.
- HOLD: Data_Valid=1. Consume without Load_Req goes to IDLE; Consume with a legal Load_Req goes to WAIT.
- Flush in any state: go to IDLE, Data_Valid=0, counter cleared, no Fault/Timeout pulse; Data_Out retained.
- Priority: Reset > Flush > Mem_Ready > timeout > Load_Req.

## Timing
- Reset values: Data_Out=0, Data_Valid=0, Busy=0, Fault=0, Timeout=0; state IDLE; counter 0.
- Mem_Ready is sampled only in WAIT, so Mem_Ready in the Load_Req cycle is ignored. Minimum latency: Load_Req at cycle 0, Mem_Ready at cycle 1, Data_Valid and Data_Out valid at cycle 2.
- Busy rises the cycle after acceptance. It falls the cycle after Mem_Ready, timeout or Flush.
- Mem_Ready on the final permitted WAIT cycle (counter == WAIT_MAX-1) wins; no Timeout.
- Data_Valid falls the cycle after Consume. Data_Out is never cleared except by Reset.
- Fault and Timeout are registered, one cycle wide, never both high.

## Structure
- Package mips_mem_pkg holds:
  - load-type constants: LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU;
  - the state enum: IDLE, WAIT, HOLD;
  - a function for type legality/alignment check.
- Sub-module load_extract: purely combinational lane select plus extend; inputs Mem_Data, latched type, latched Addr_Lsb; output 32-bit result. Reused by the future store-merge path.

## Test plan
- Reset mid-WAIT, then LB at Addr_Lsb=10 with Mem_Data=32'h12_80_34_56, Mem_Ready 2 cycles later -> Data_Out=32'hFFFF_FF80, Data_Valid=1 at the following cycle.
- LHU at Addr_Lsb=10, Mem_Data=32'h8001_7FFF -> 32'h0000_8001. LH at Addr_Lsb=00 on the same word -> 32'h0000_7FFF. LW -> 32'h8001_7FFF.
- LH at Addr_Lsb=01, and Load_Type=010 -> Fault pulse of 1 cycle each; Busy never rises; Data_Out unchanged.
- WAIT_MAX=4, Mem_Ready withheld -> Timeout pulse 5 cycles after Load_Req, state IDLE. Repeat with Mem_Ready on the 4th WAIT cycle -> capture, no Timeout.
- HOLD with Consume and a new LBU in the same cycle -> Data_Valid drops, Busy rises next cycle. Load_Req in HOLD without Consume is ignored.
- Flush during WAIT, then a late Mem_Ready -> no capture; Data_Out keeps the prior value; no pulses.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - load-type constants, FSM states and legality check for mem_load_reg
package mips_mem_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // Halfwords need an even address, words a zero byte offset; bytes go anywhere.
    function automatic logic load_legal(input logic [2:0] load_type, input logic [1:0] addr_lsb);
        case (load_type)
            LT_LB, LT_LBU: load_legal = 1'b1;
            LT_LH, LT_LHU: load_legal = ~addr_lsb[0];
            LT_LW:         load_legal = (addr_lsb == 2'b00);
            default:       load_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_reg_if.sv
// rtl/mem_load_reg_if.sv - request/memory/result signal bundle for mem_load_reg
interface mem_load_reg_if;
    logic        Load_Req;
    logic [2:0]  Load_Type;
    logic [1:0]  Addr_Lsb;
    logic        Flush;
    logic        Consume;
    logic        Mem_Ready;
    logic [31:0] Mem_Data;
    logic [31:0] Data_Out;
    logic        Data_Valid;
    logic        Busy;
    logic        Fault;
    logic        Timeout;

    modport master (
        output Load_Req, Load_Type, Addr_Lsb, Flush, Consume, Mem_Ready, Mem_Data,
        input  Data_Out, Data_Valid, Busy, Fault, Timeout
    );

    modport slave (
        input  Load_Req, Load_Type, Addr_Lsb, Flush, Consume, Mem_Ready, Mem_Data,
        output Data_Out, Data_Valid, Busy, Fault, Timeout
    );
endinterface

// File: rtl/mem_load_reg_extract.sv
// rtl/mem_load_reg_extract.sv - little-endian lane select plus sign/zero extension
module load_extract
    import mips_mem_pkg::*;
(
    input  logic [31:0] mem_data_i,
    input  logic [2:0]  load_type_i,
    input  logic [1:0]  addr_lsb_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        case (addr_lsb_i)
            2'd0:    byte_w = mem_data_i[7:0];
            2'd1:    byte_w = mem_data_i[15:8];
            2'd2:    byte_w = mem_data_i[23:16];
            default: byte_w = mem_data_i[31:24];
        endcase
        half_w = addr_lsb_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];

        case (load_type_i)
            LT_LB:   result_o = {{24{byte_w[7]}}, byte_w};
            LT_LH:   result_o = {{16{half_w[15]}}, half_w};
            LT_LBU:  result_o = {24'd0, byte_w};
            LT_LHU:  result_o = {16'd0, half_w};
            default: result_o = mem_data_i;
        endcase
    end

endmodule

// File: rtl/mem_load_reg.sv
// rtl/mem_load_reg.sv - memory data register with load-type extraction, timeout and fault pulses
module mem_load_reg
    import mips_mem_pkg::*;
#(
    parameter  int WAIT_MAX = 15,
    localparam int CNT_W    = $clog2(WAIT_MAX + 1)
) (
    input  logic           CLK,
    input  logic           Reset,
    mem_load_reg_if.slave  bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         type_q, type_d;
    logic [1:0]         lsb_q, lsb_d;
    logic [31:0]        data_q, data_d;
    logic               fault_q, fault_d;
    logic               timeout_q, timeout_d;
    logic [31:0]        extract_w;
    logic               accept_w;

    load_extract u_extract (
        .mem_data_i  (bus.Mem_Data),
        .load_type_i (type_q),
        .addr_lsb_i  (lsb_q),
        .result_o    (extract_w)
    );

    // A held result must be consumed in the same cycle before a new load can start.
    assign accept_w = bus.Load_Req &&
                      ((state_q == S_IDLE) || ((state_q == S_HOLD) && bus.Consume));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        type_d    = type_q;
        lsb_d     = lsb_q;
        data_d    = data_q;
        fault_d   = 1'b0;
        timeout_d = 1'b0;

        if (bus.Flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (bus.Mem_Ready) begin
                        data_d  = extract_w;
                        state_d = S_HOLD;
                    end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (bus.Consume) state_d = S_IDLE;
                end
                default: ;
            endcase

            if (accept_w) begin
                type_d = bus.Load_Type;
                lsb_d  = bus.Addr_Lsb;
                if (load_legal(bus.Load_Type, bus.Addr_Lsb)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    fault_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            type_q    <= '0;
            lsb_q     <= '0;
            data_q    <= '0;
            fault_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            lsb_q     <= lsb_d;
            data_q    <= data_d;
            fault_q   <= fault_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.Data_Out   = data_q;
    assign bus.Data_Valid = (state_q == S_HOLD);
    assign bus.Busy       = (state_q == S_WAIT);
    assign bus.Fault      = fault_q;
    assign bus.Timeout    = timeout_q;

endmodule

// File: tb/tb_mem_load_reg.sv
// tb/tb_mem_load_reg.sv - self-checking bench for mem_load_reg against a behavioural load model
module tb_mem_load_reg;
    import mips_mem_pkg::*;

    localparam int WM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_out = 32'd0;
    logic        exp_valid = 1'b0;

    mem_load_reg_if bus();

    mem_load_reg #(.WAIT_MAX(WM)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_extract(input logic [2:0] t, input logic [1:0] a,
                                                input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(a))) % 256;
        h = (w >> (16 * (int'(a) / 2))) % 65536;
        case (t)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd3:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [2:0] t, input logic [1:0] a);
        case (t)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (a % 2) == 0;
            3'd3:       return a == 2'd0;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] t, input logic [1:0] a, input logic consume);
        bus.Load_Req  = 1'b1;
        bus.Load_Type = t;
        bus.Addr_Lsb  = a;
        bus.Consume   = consume;
        tick();
        bus.Load_Req  = 1'b0;
        bus.Consume   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.Data_Out !== 32'd0) begin errors++; $display("FAIL reset_data_out: got %h expected %h", bus.Data_Out, 32'd0); end
        checks++; if (bus.Data_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.Data_Valid); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        checks++; if (bus.Fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", bus.Fault); end
        checks++; if (bus.Timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.Timeout); end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] exp;
        bus.Mem_Data = 32'h1280_3456;
        issue(LT_LW, 2'd0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_out = 32'd0;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL midwait_reset_busy: got %b expected 0", bus.Busy); end
        issue(LT_LB, 2'd2, 1'b0);
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL lb_busy: got %b expected 1", bus.Busy); end
        tick();
        bus.Mem_Ready = 1'b1;
        tick();
        bus.Mem_Ready = 1'b0;
        exp = ref_extract(LT_LB, 2'd2, 32'h1280_3456);
        exp_out = exp;
        checks++; if (bus.Data_Out !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected %h", bus.Data_Out, 32'hFFFF_FF80); end
        checks++; if (bus.Data_Out !== exp) begin errors++; $display("FAIL lb_model: got %h expected %h", bus.Data_Out, exp); end
        checks++; if (bus.Data_Valid !== 1'b1) begin errors++; $display("FAIL lb_valid: got %b expected 1", bus.Data_Valid); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL lb_busy_fall: got %b expected 0", bus.Busy); end
        bus.Consume = 1'b1;
        tick();
        bus.Consume = 1'b0;
        checks++; if (bus.Data_Valid !== 1'b0) begin errors++; $display("FAIL consume_valid: got %b expected 0", bus.Data_Valid); end
        checks++; if (bus.Data_Out !== exp_out) begin errors++; $display("FAIL consume_retain: got %h expected %h", bus.Data_Out, exp_out); end
    endtask

    task automatic test_extensions;
        logic [2:0]  types [3] = '{LT_LHU, LT_LH, LT_LW};
        logic [1:0]  lsbs  [3] = '{2'd2, 2'd0, 2'd0};
        logic [31:0] wants [3] = '{32'h0000_8001, 32'h0000_7FFF, 32'h8001_7FFF};
        for (int i = 0; i < 3; i++) begin
            bus.Mem_Data = 32'h8001_7FFF;
            issue(types[i], lsbs[i], 1'b0);
            bus.Mem_Ready = 1'b1;
            tick();
            bus.Mem_Ready = 1'b0;
            exp_out = ref_extract(types[i], lsbs[i], 32'h8001_7FFF);
            checks++; if (bus.Data_Out !== wants[i]) begin errors++; $display("FAIL ext_const[%0d]: got %h expected %h", i, bus.Data_Out, wants[i]); end
            checks++; if (bus.Data_Out !== exp_out) begin errors++; $display("FAIL ext_model[%0d]: got %h expected %h", i, bus.Data_Out, exp_out); end
            bus.Consume = 1'b1;
            tick();
            bus.Consume = 1'b0;
        end
    endtask

    task automatic test_fault;
        logic [2:0] types [2] = '{LT_LH, 3'b010};
        logic [1:0] lsbs  [2] = '{2'd1, 2'd0};
        for (int i = 0; i < 2; i++) begin
            issue(types[i], lsbs[i], 1'b0);
            checks++; if (bus.Fault !== 1'b1) begin errors++; $display("FAIL fault_pulse[%0d]: got %b expected 1", i, bus.Fault); end
            checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL fault_busy[%0d]: got %b expected 0", i, bus.Busy); end
            checks++; if (bus.Data_Out !== exp_out) begin errors++; $display("FAIL fault_data[%0d]: got %h expected %h", i, bus.Data_Out, exp_out); end
            tick();
            checks++; if (bus.Fault !== 1'b0) begin errors++; $display("FAIL fault_width[%0d]: got %b expected 0", i, bus.Fault); end
            checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL fault_busy2[%0d]: got %b expected 0", i, bus.Busy); end
        end
    endtask

    task automatic test_timeout;
        issue(LT_LW, 2'd0, 1'b0);
        repeat (WM - 1) tick();
        checks++; if (bus.Timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", bus.Timeout); end
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL timeout_busy: got %b expected 1", bus.Busy); end
        tick();
        checks++; if (bus.Timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b expected 1", bus.Timeout); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got %b expected 0", bus.Busy); end
        checks++; if (bus.Fault !== 1'b0) begin errors++; $display("FAIL timeout_nofault: got %b expected 0", bus.Fault); end
        tick();
        checks++; if (bus.Timeout !== 1'b0) begin errors++; $display("FAIL timeout_width: got %b expected 0", bus.Timeout); end

        issue(LT_LW, 2'd0, 1'b0);
        repeat (WM - 1) tick();
        bus.Mem_Data  = 32'hCAFE_F00D;
        bus.Mem_Ready = 1'b1;
        tick();
        bus.Mem_Ready = 1'b0;
        exp_out = 32'hCAFE_F00D;
        checks++; if (bus.Timeout !== 1'b0) begin errors++; $display("FAIL last_cycle_timeout: got %b expected 0", bus.Timeout); end
        checks++; if (bus.Data_Valid !== 1'b1) begin errors++; $display("FAIL last_cycle_valid: got %b expected 1", bus.Data_Valid); end
        checks++; if (bus.Data_Out !== exp_out) begin errors++; $display("FAIL last_cycle_data: got %h expected %h", bus.Data_Out, exp_out); end
        tick();
        checks++; if (bus.Timeout !== 1'b0) begin errors++; $display("FAIL last_cycle_late_timeout: got %b expected 0", bus.Timeout); end
    endtask

    task automatic test_back_to_back;
        issue(LT_LBU, 2'd3, 1'b0);
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL hold_ignore_busy: got %b expected 0", bus.Busy); end
        checks++; if (bus.Data_Valid !== 1'b1) begin errors++; $display("FAIL hold_ignore_valid: got %b expected 1", bus.Data_Valid); end
        issue(LT_LBU, 2'd3, 1'b1);
        checks++; if (bus.Data_Valid !== 1'b0) begin errors++; $display("FAIL b2b_valid: got %b expected 0", bus.Data_Valid); end
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", bus.Busy); end
        bus.Mem_Data  = 32'hA500_0000;
        bus.Mem_Ready = 1'b1;
        tick();
        bus.Mem_Ready = 1'b0;
        exp_out = ref_extract(LT_LBU, 2'd3, 32'hA500_0000);
        checks++; if (bus.Data_Out !== exp_out) begin errors++; $display("FAIL b2b_data: got %h expected %h", bus.Data_Out, exp_out); end
    endtask

    task automatic test_flush;
        bus.Consume = 1'b1;
        tick();
        bus.Consume = 1'b0;
        issue(LT_LW, 2'd0, 1'b0);
        tick();
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", bus.Busy); end
        checks++; if (bus.Fault !== 1'b0 || bus.Timeout !== 1'b0) begin errors++; $display("FAIL flush_pulses: got %b%b expected 00", bus.Fault, bus.Timeout); end
        bus.Mem_Data  = 32'hDEAD_BEEF;
        bus.Mem_Ready = 1'b1;
        tick();
        bus.Mem_Ready = 1'b0;
        checks++; if (bus.Data_Valid !== 1'b0) begin errors++; $display("FAIL flush_late_valid: got %b expected 0", bus.Data_Valid); end
        checks++; if (bus.Data_Out !== exp_out) begin errors++; $display("FAIL flush_late_data: got %h expected %h", bus.Data_Out, exp_out); end
        tick();
        checks++; if (bus.Fault !== 1'b0 || bus.Timeout !== 1'b0) begin errors++; $display("FAIL flush_late_pulses: got %b%b expected 00", bus.Fault, bus.Timeout); end
        exp_valid = 1'b0;
    endtask

    task automatic test_random;
        logic [2:0] pool [8] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd2, 3'd6, 3'd7};
        logic [2:0] t;
        logic [1:0] a;
        int         delay;
        for (int n = 0; n < 60; n++) begin
            t = pool[$urandom_range(0, 7)];
            a = 2'($urandom_range(0, 3));
            delay = $urandom_range(0, WM);
            bus.Mem_Data = $urandom;
            issue(t, a, exp_valid);
            if (!ref_legal(t, a)) begin
                exp_valid = 1'b0;
                checks++; if (bus.Fault !== 1'b1 || bus.Busy !== 1'b0) begin errors++; $display("FAIL rnd_fault[%0d]: got fault=%b busy=%b expected fault=1 busy=0", n, bus.Fault, bus.Busy); end
                checks++; if (bus.Data_Out !== exp_out) begin errors++; $display("FAIL rnd_fault_data[%0d]: got %h expected %h", n, bus.Data_Out, exp_out); end
            end else begin
                checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected 1", n, bus.Busy); end
                for (int k = 0; k < WM; k++) begin
                    bus.Mem_Data  = $urandom;
                    bus.Mem_Ready = (k == delay);
                    if (k == delay) begin
                        exp_out   = ref_extract(t, a, bus.Mem_Data);
                        exp_valid = 1'b1;
                    end
                    tick();
                    bus.Mem_Ready = 1'b0;
                    if (k == delay) begin
                        checks++; if (bus.Data_Valid !== 1'b1 || bus.Data_Out !== exp_out) begin errors++; $display("FAIL rnd_capture[%0d]: got valid=%b data=%h expected valid=1 data=%h", n, bus.Data_Valid, bus.Data_Out, exp_out); end
                        break;
                    end
                    if (k == WM - 1) begin
                        exp_valid = 1'b0;
                        checks++; if (bus.Timeout !== 1'b1 || bus.Data_Valid !== 1'b0) begin errors++; $display("FAIL rnd_timeout[%0d]: got timeout=%b valid=%b expected timeout=1 valid=0", n, bus.Timeout, bus.Data_Valid); end
                        checks++; if (bus.Data_Out !== exp_out) begin errors++; $display("FAIL rnd_timeout_data[%0d]: got %h expected %h", n, bus.Data_Out, exp_out); end
                    end
                end
            end
        end
    endtask

    initial begin
        bus.Load_Req  = 1'b0;
        bus.Load_Type = 3'd0;
        bus.Addr_Lsb  = 2'd0;
        bus.Flush     = 1'b0;
        bus.Consume   = 1'b0;
        bus.Mem_Ready = 1'b0;
        bus.Mem_Data  = 32'd0;
        test_reset();
        test_reset_mid_wait();
        test_extensions();
        test_fault();
        test_timeout();
        test_back_to_back();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
